// File: rtl/axi_burst_wr_master_pkg.sv
// Shared AXI write-path definitions: burst/response encodings, FSM states and
// the 4KB page check used when accepting a burst request.
package axi_burst_wr_master_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int unsigned BOUNDARY_4K = 32'd4096;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2,
        ERR    = 2'd3
    } state_t;

    // True when a burst of 'beats' beats of 2**size bytes starting at 'page_off' leaves its 4KB page
    function automatic logic crosses_4k(input logic [11:0] page_off,
                                        input logic [31:0] beats,
                                        input logic [2:0]  size);
        logic [31:0] span;
        span = beats << size;
        return (32'(page_off) + span) > 32'(BOUNDARY_4K);
    endfunction

endpackage

// File: rtl/axi_wlane_align.sv
// Places a right-justified beat onto the AXI write lanes for its byte address
// and builds the matching strobe (narrow and unaligned first beats included).
module axi_wlane_align
    import axi_burst_wr_master_pkg::*;
#(
    parameter  int DATA_W = 64,
    localparam int STRB_W = DATA_W / 8,
    localparam int OFF_W  = $clog2(STRB_W)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [OFF_W-1:0]  off,
    input  logic [2:0]        size,
    input  logic              first,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb
);

    logic [OFF_W:0]   beat_bytes_s;
    logic [OFF_W-1:0] lane_base_s;

    // Lanes covered by the size-aligned beat; the first beat drops bytes below the start address
    always_comb begin
        beat_bytes_s = (OFF_W + 1)'(1) << size;
        lane_base_s  = off & ~(beat_bytes_s[OFF_W-1:0] - OFF_W'(1));
        wdata        = data << {off, 3'b000};
        wstrb        = '0;
        for (int i = 0; i < STRB_W; i++) begin
            wstrb[i] = (i >= int'(lane_base_s)) &&
                       (i < int'(lane_base_s) + int'(beat_bytes_s)) &&
                       (!first || (i >= int'(off)));
        end
    end

endmodule

// File: rtl/axi_burst_wr_master.sv
// AXI4 write master: one INCR burst at a time, per-beat handshaked data through a
// one-entry buffer, optional AW/W overlap and up-front size / 4KB request checking.
module axi_burst_wr_master
    import axi_burst_wr_master_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 32,
    parameter int ID_W    = 4,
    parameter int LEN_W   = 8,
    parameter bit OVERLAP = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ID_W-1:0]       req_id,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [LEN_W-1:0]      req_len,
    input  logic [2:0]            req_size,
    input  logic                  wbeat_valid,
    output logic                  wbeat_ready,
    input  logic [DATA_W-1:0]     wbeat_data,
    output logic                  rsp_valid,
    output logic [1:0]            rsp_resp,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ID_W-1:0]       awid,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [LEN_W-1:0]      awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic                  wvalid,
    input  logic                  wready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wlast,
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [ID_W-1:0]       bid,
    input  logic [1:0]            bresp
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int CNT_W  = LEN_W + 1;

    state_t              state_r;
    logic [CNT_W-1:0]    beats_in_r;
    logic [CNT_W-1:0]    beats_out_r;
    logic [ADDR_W-1:0]   in_addr_r;
    logic                buf_full_r;
    logic                aw_done_r;
    logic                w_done_r;

    logic                aw_hs_s;
    logic                w_hs_s;
    logic                beat_hs_s;
    logic                aw_done_nx_s;
    logic                w_done_nx_s;
    logic                buf_full_nx_s;
    logic                req_err_s;
    logic [ADDR_W-1:0]   beat_bytes_s;
    logic [ADDR_W-1:0]   next_addr_s;
    logic [DATA_W-1:0]   align_data_s;
    logic [STRB_W-1:0]   align_strb_s;

    assign req_ready     = (state_r == IDLE);
    assign awburst       = AXI_BURST_INCR;
    assign aw_hs_s       = awvalid & awready;
    assign w_hs_s        = wvalid & wready;
    // A beat may enter the buffer in the same cycle the previous one leaves on W
    assign wbeat_ready   = (state_r == ACTIVE) && (beats_in_r <= {1'b0, awlen}) &&
                           (!buf_full_r || w_hs_s);
    assign beat_hs_s     = wbeat_valid & wbeat_ready;
    assign aw_done_nx_s  = aw_done_r | aw_hs_s;
    assign w_done_nx_s   = w_done_r | (w_hs_s && (beats_out_r == {1'b0, awlen}));
    assign buf_full_nx_s = beat_hs_s | (buf_full_r & ~w_hs_s);
    assign req_err_s     = (req_size > 3'(OFF_W)) ||
                           crosses_4k(req_addr[11:0], 32'(req_len) + 32'd1, req_size);

    // The buffered beat's address advances to the next size-aligned beat once it is loaded
    assign beat_bytes_s  = ADDR_W'(1) << awsize;
    assign next_addr_s   = (in_addr_r & ~(beat_bytes_s - ADDR_W'(1))) + beat_bytes_s;

    axi_wlane_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .data  (wbeat_data),
        .off   (in_addr_r[OFF_W-1:0]),
        .size  (awsize),
        .first (beats_in_r == '0),
        .wdata (align_data_s),
        .wstrb (align_strb_s)
    );

    // Burst control FSM; all AXI channel and completion outputs are registered here
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            awvalid     <= 1'b0;
            awid        <= '0;
            awaddr      <= '0;
            awlen       <= '0;
            awsize      <= 3'd0;
            wvalid      <= 1'b0;
            wdata       <= '0;
            wstrb       <= '0;
            wlast       <= 1'b0;
            bready      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_resp    <= 2'b00;
            rsp_id      <= '0;
            beats_in_r  <= '0;
            beats_out_r <= '0;
            in_addr_r   <= '0;
            buf_full_r  <= 1'b0;
            aw_done_r   <= 1'b0;
            w_done_r    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        awid        <= req_id;
                        awaddr      <= req_addr;
                        awlen       <= req_len;
                        awsize      <= req_size;
                        in_addr_r   <= req_addr;
                        beats_in_r  <= '0;
                        beats_out_r <= '0;
                        buf_full_r  <= 1'b0;
                        aw_done_r   <= 1'b0;
                        w_done_r    <= 1'b0;
                        if (req_err_s) begin
                            state_r <= ERR;
                        end else begin
                            state_r <= ACTIVE;
                            awvalid <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACTIVE: begin
                    if (aw_hs_s) begin
                        awvalid   <= 1'b0;
                        aw_done_r <= 1'b1;
                    end
                    if (beat_hs_s) begin
                        wdata      <= align_data_s;
                        wstrb      <= align_strb_s;
                        wlast      <= (beats_in_r == {1'b0, awlen});
                        beats_in_r <= beats_in_r + CNT_W'(1);
                        in_addr_r  <= next_addr_s;
                    end
                    if (w_hs_s) begin
                        beats_out_r <= beats_out_r + CNT_W'(1);
                    end
                    buf_full_r <= buf_full_nx_s;
                    w_done_r   <= w_done_nx_s;
                    wvalid     <= buf_full_nx_s & (OVERLAP | aw_done_nx_s);
                    if (aw_done_nx_s && w_done_nx_s) begin
                        state_r <= RESP;
                        bready  <= 1'b1;
                    end else begin
                        state_r <= ACTIVE;
                    end
                end
                RESP: begin
                    if (bvalid) begin
                        bready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_id    <= bid;
                        rsp_resp  <= (bid == awid) ? bresp : AXI_RESP_SLVERR;
                        state_r   <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                ERR: begin
                    rsp_valid <= 1'b1;
                    rsp_resp  <= AXI_RESP_SLVERR;
                    rsp_id    <= awid;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_wr_master.sv
// Drives two masters (OVERLAP=0 and OVERLAP=1) through directed and random bursts
// against a byte-address reference model and an AXI slave with random stalls.
`timescale 1ns/1ps
module tb_axi_burst_wr_master;
    import axi_burst_wr_master_pkg::*;

    localparam int DW = 64;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic          req_valid [2], req_ready [2];
    logic [IW-1:0] req_id    [2];
    logic [AW-1:0] req_addr  [2];
    logic [LW-1:0] req_len   [2];
    logic [2:0]    req_size  [2];
    logic          wbeat_valid [2], wbeat_ready [2];
    logic [DW-1:0] wbeat_data  [2];
    logic          rsp_valid [2];
    logic [1:0]    rsp_resp  [2];
    logic [IW-1:0] rsp_id    [2];
    logic          awvalid [2], awready [2];
    logic [IW-1:0] awid    [2];
    logic [AW-1:0] awaddr  [2];
    logic [LW-1:0] awlen   [2];
    logic [2:0]    awsize  [2];
    logic [1:0]    awburst [2];
    logic          wvalid [2], wready [2], wlast [2];
    logic [DW-1:0] wdata  [2];
    logic [7:0]    wstrb  [2];
    logic          bvalid [2], bready [2];
    logic [IW-1:0] bid    [2];
    logic [1:0]    bresp  [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axi_burst_wr_master #(
            .DATA_W(DW), .ADDR_W(AW), .ID_W(IW), .LEN_W(LW), .OVERLAP(g == 1)
        ) dut (
            .clk(clk), .reset_n(reset_n),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_id(req_id[g]),
            .req_addr(req_addr[g]), .req_len(req_len[g]), .req_size(req_size[g]),
            .wbeat_valid(wbeat_valid[g]), .wbeat_ready(wbeat_ready[g]), .wbeat_data(wbeat_data[g]),
            .rsp_valid(rsp_valid[g]), .rsp_resp(rsp_resp[g]), .rsp_id(rsp_id[g]),
            .awvalid(awvalid[g]), .awready(awready[g]), .awid(awid[g]), .awaddr(awaddr[g]),
            .awlen(awlen[g]), .awsize(awsize[g]), .awburst(awburst[g]),
            .wvalid(wvalid[g]), .wready(wready[g]), .wdata(wdata[g]), .wstrb(wstrb[g]),
            .wlast(wlast[g]),
            .bvalid(bvalid[g]), .bready(bready[g]), .bid(bid[g]), .bresp(bresp[g])
        );
    end

    typedef struct {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [2:0]    size;
        logic [DW-1:0] base;
        int            aw_delay;
        int            w_pct;
        logic [1:0]    bresp;
        bit            bid_flip;
        int            rst_after;
        bit            use_exp;
        logic [1:0]    exp_resp;
        logic [31:0]   exp_strb;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic vec_t mk(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                                input logic [LW-1:0] len, input logic [2:0] size,
                                input logic [DW-1:0] base, input int aw_delay, input int w_pct,
                                input logic [1:0] br, input bit flip, input int rst_after,
                                input logic [1:0] exp_resp, input logic [31:0] exp_strb);
        vec_t v;
        v.id = id; v.addr = addr; v.len = len; v.size = size; v.base = base;
        v.aw_delay = aw_delay; v.w_pct = w_pct; v.bresp = br; v.bid_flip = flip;
        v.rst_after = rst_after; v.use_exp = 1'b1; v.exp_resp = exp_resp; v.exp_strb = exp_strb;
        return v;
    endfunction

    // Reference model: byte address range written by beat k
    function automatic longint m_lo(input logic [AW-1:0] addr, input logic [2:0] size, input int k);
        longint nb, al;
        nb = longint'(1) << size;
        al = (longint'(addr) / nb) * nb;
        return (k == 0) ? longint'(addr) : al + longint'(k) * nb;
    endfunction

    function automatic logic [7:0] m_strb(input logic [AW-1:0] addr, input logic [2:0] size, input int k);
        longint nb, al, lo, hi, b;
        logic [7:0] s;
        nb = longint'(1) << size;
        al = (longint'(addr) / nb) * nb;
        lo = m_lo(addr, size, k);
        hi = al + longint'(k + 1) * nb;
        s  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            b    = (lo / 8) * 8 + longint'(i);
            s[i] = (b >= lo) && (b < hi);
        end
        return s;
    endfunction

    function automatic logic [DW-1:0] m_data(input vec_t v, input int k);
        longint lo;
        lo = m_lo(v.addr, v.size, k);
        return (v.base + 64'(k)) << (8 * (lo % 8));
    endfunction

    function automatic bit m_err(input vec_t v);
        return (v.size > 3'd3) ||
               ((int'(v.addr % 4096) + (int'(v.len) + 1) * (1 << v.size)) > 4096);
    endfunction

    task automatic idle_inputs(input int d);
        req_valid[d] = 1'b0; req_id[d] = '0; req_addr[d] = '0; req_len[d] = '0; req_size[d] = 3'd0;
        wbeat_valid[d] = 1'b0; wbeat_data[d] = '0;
        awready[d] = 1'b0; wready[d] = 1'b0;
        bvalid[d] = 1'b0; bid[d] = '0; bresp[d] = 2'b00;
    endtask

    task automatic run_burst(input int d, input vec_t v);
        int aw_wait = 0, nb_acc = 0, w_cnt = 0, aw_cnt = 0, rsp_cnt = 0, post = -1, b_delay;
        bit req_acc = 0, aw_seen = 0, w_last_seen = 0, b_done = 0, aw_stall = 0, w_stall = 0;
        bit err, done = 0;
        logic [47:0] s_aw;
        logic [73:0] s_w;
        logic [1:0] got_resp = 2'b00, e_resp;
        logic [IW-1:0] got_id = '0, e_id, b_id_drv;
        err      = m_err(v);
        b_id_drv = v.id ^ {3'b000, v.bid_flip};
        e_resp   = v.use_exp ? v.exp_resp : (err ? 2'b10 : (v.bid_flip ? 2'b10 : v.bresp));
        e_id     = err ? v.id : b_id_drv;
        b_delay  = $urandom_range(2, 0);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            if (v.rst_after > 0 && w_cnt == v.rst_after) begin
                reset_n = 1'b0;
                idle_inputs(d);
                @(posedge clk); #1;
                reset_n = 1'b1;
                @(negedge clk);
                chk("rst_valids", {awvalid[d], wvalid[d], bready[d], rsp_valid[d], req_ready[d]}, 5'b00001);
                chk("rst_fields", {awaddr[d], wstrb[d], wlast[d]}, '0);
                return;
            end
            req_valid[d]   = !req_acc;
            req_id[d]      = v.id; req_addr[d] = v.addr; req_len[d] = v.len; req_size[d] = v.size;
            wbeat_valid[d] = (nb_acc <= int'(v.len)) && ($urandom_range(99, 0) < v.w_pct);
            wbeat_data[d]  = v.base + 64'(nb_acc);
            awready[d]     = (aw_wait >= v.aw_delay);
            wready[d]      = ($urandom_range(99, 0) < v.w_pct);
            bid[d]         = b_id_drv;
            bresp[d]       = v.bresp;
            if (aw_seen && w_last_seen && !b_done) begin
                if (b_delay > 0) begin b_delay--; bvalid[d] = 1'b0; end
                else bvalid[d] = 1'b1;
            end else bvalid[d] = 1'b0;

            @(negedge clk);
            if (req_valid[d] && req_ready[d]) req_acc = 1;
            if (aw_stall) chk("aw_stable", {awvalid[d], awaddr[d], awlen[d], awsize[d], awid[d]}, s_aw);
            if (w_stall)  chk("w_stable", {wvalid[d], wdata[d], wstrb[d], wlast[d]}, s_w);
            if (wvalid[d] && d == 0) chk("no_w_before_aw", aw_seen, 1'b1);
            if (awvalid[d]) begin
                aw_wait++;
                if (awready[d]) begin
                    aw_cnt++; aw_seen = 1;
                    chk("aw_fields", {awaddr[d], awlen[d], awsize[d], awid[d], awburst[d]},
                        {v.addr, v.len, v.size, v.id, 2'b01});
                end
            end
            aw_stall = awvalid[d] && !awready[d];
            s_aw     = {1'b1, awaddr[d], awlen[d], awsize[d], awid[d]};
            if (wvalid[d] && wready[d]) begin
                chk("wdata", wdata[d], m_data(v, w_cnt));
                chk("wstrb", wstrb[d], m_strb(v.addr, v.size, w_cnt));
                chk("wlast", wlast[d], w_cnt == int'(v.len));
                if (v.use_exp && w_cnt < 4) chk("wstrb_tbl", wstrb[d], v.exp_strb[8*w_cnt +: 8]);
                if (w_cnt == int'(v.len)) w_last_seen = 1;
                w_cnt++;
            end
            w_stall = wvalid[d] && !wready[d];
            s_w     = {1'b1, wdata[d], wstrb[d], wlast[d]};
            if (wbeat_valid[d] && wbeat_ready[d]) nb_acc++;
            if (bvalid[d] && bready[d]) b_done = 1;
            if (rsp_valid[d]) begin
                rsp_cnt++; got_resp = rsp_resp[d]; got_id = rsp_id[d];
                if (post < 0) post = 2;
            end
            if (post == 0) begin done = 1; break; end
            if (post > 0) post--;
        end
        idle_inputs(d);
        if (!done) chk("timeout", 1'b0, 1'b1);
        chk("rsp_count", rsp_cnt, 1);
        chk("aw_count", aw_cnt, err ? 0 : 1);
        if (err) chk("no_awvalid", aw_wait, 0);
        chk("w_count", w_cnt, err ? 0 : int'(v.len) + 1);
        chk("rsp_resp", got_resp, e_resp);
        chk("rsp_id", got_id, e_id);
    endtask

    vec_t tbl [12];
    vec_t rv;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mk(4'd1,  32'h8000_0004, 8'd0,   3'd2, 64'hDEAD_BEEF, 0, 100, 2'b00, 0, 0, 2'b00, 32'h0000_00F0);
        tbl[1]  = mk(4'd2,  32'h0000_0100, 8'd3,   3'd3, 64'd1,         0, 100, 2'b00, 0, 0, 2'b00, 32'hFFFF_FFFF);
        tbl[2]  = mk(4'd3,  32'h0000_0103, 8'd2,   3'd1, 64'h1122,      0, 100, 2'b00, 0, 0, 2'b00, 32'h00C0_3008);
        tbl[3]  = mk(4'd4,  32'h0000_0200, 8'd5,   3'd2, 64'h100,       5,  50, 2'b00, 0, 0, 2'b00, 32'hF00F_F00F);
        tbl[4]  = mk(4'd5,  32'h0000_0040, 8'd0,   3'd4, 64'h5,         0, 100, 2'b00, 0, 0, 2'b10, 32'h0);
        tbl[5]  = mk(4'd6,  32'h0000_0FF8, 8'd1,   3'd3, 64'h6,         0, 100, 2'b00, 0, 0, 2'b10, 32'h0);
        tbl[6]  = mk(4'd7,  32'h0000_0300, 8'd1,   3'd3, 64'h700,       0, 100, 2'b11, 0, 0, 2'b11, 32'h0000_FFFF);
        tbl[7]  = mk(4'd8,  32'h0000_0400, 8'd0,   3'd3, 64'h800,       0, 100, 2'b00, 1, 0, 2'b10, 32'h0000_00FF);
        tbl[8]  = mk(4'd9,  32'h0000_0500, 8'd3,   3'd3, 64'h900,       0, 100, 2'b00, 0, 2, 2'b00, 32'hFFFF_FFFF);
        tbl[9]  = mk(4'd10, 32'h0000_0601, 8'd0,   3'd0, 64'hA5,        0, 100, 2'b00, 0, 0, 2'b00, 32'h0000_0002);
        tbl[10] = mk(4'd11, 32'h0000_0FF0, 8'd1,   3'd3, 64'hB00,       0, 100, 2'b00, 0, 0, 2'b00, 32'h0000_FFFF);
        tbl[11] = mk(4'd12, 32'h0000_0000, 8'd255, 3'd0, 64'hC00,       0, 100, 2'b00, 0, 0, 2'b00, 32'h0804_0201);

        reset_n = 1'b0;
        idle_inputs(0);
        idle_inputs(1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_valids", {awvalid[d], wvalid[d], wlast[d], bready[d], rsp_valid[d], req_ready[d]}, 6'b000001);
            chk("reset_fields", {awaddr[d], awlen[d], awid[d], wdata[d], wstrb[d], rsp_resp[d], rsp_id[d]}, '0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 12; i++) run_burst(d, tbl[i]);
            for (int r = 0; r < 12; r++) begin
                rv.id        = 4'($urandom);
                rv.addr      = $urandom_range(32'h1FFF, 0);
                rv.len       = 8'($urandom_range(7, 0));
                rv.size      = ($urandom_range(9, 0) == 0) ? 3'd4 : 3'($urandom_range(3, 0));
                rv.base      = {$urandom, $urandom};
                rv.aw_delay  = $urandom_range(6, 0);
                rv.w_pct     = $urandom_range(100, 30);
                rv.bresp     = 2'($urandom);
                rv.bid_flip  = ($urandom_range(7, 0) == 0);
                rv.rst_after = 0;
                rv.use_exp   = 1'b0;
                rv.exp_resp  = 2'b00;
                rv.exp_strb  = 32'h0;
                run_burst(d, rv);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
